bus_access_sequencer: RTL
=========================

// Module: bus_access_sequencer
// PURPOSE
//  Master-facing front end of the peripheral read/write path. Decodes a request address
//  against three slave regions and drives the one-hot addr_valid1..3 with ren/wen to the
//  slaves. Holds the select for the slave's fixed wait-state count, then captures the
//  arbitrated rdata and returns a one-cycle ready (error if the address is unmapped).
// PARAMETERS
//  BASE1  32'h8000_0000  region 1 base; hit when (addr & MASK1) == BASE1
//  MASK1  32'hFFFF_0000  region 1 compare mask
//  BASE2  32'h8001_0000  region 2 base
//  MASK2  32'hFFFF_0000  region 2 compare mask
//  BASE3  32'h8002_0000  region 3 base
//  MASK3  32'hFFFF_0000  region 3 compare mask
//  LAT1   0              region 1 extra wait cycles, 0..15
//  LAT2   2              region 2 extra wait cycles, 0..15
//  LAT3   5              region 3 extra wait cycles, 0..15
// PORTS
//  CLK          in   1   clock, rising edge
//  nRST         in   1   async active-low reset
//  req_addr     in   32  request address; sampled only in IDLE
//  req_ren      in   1   read request pulse; sampled only in IDLE
//  req_wen      in   1   write request pulse; sampled only in IDLE
//  req_wdata    in   32  write data; sampled with req_wen
//  busy         out  1   1 while not IDLE
//  ready        out  1   one-cycle completion strobe
//  error        out  1   qualifies ready: unmapped address or ren&wen together
//  rdata_out    out  32  captured read data; valid when ready & ~error & read
//  addr_valid1  out  1   region 1 select (one-hot with 2,3)
//  addr_valid2  out  1   region 2 select
//  addr_valid3  out  1   region 3 select
//  ren          out  1   slave read enable, ACCESS only
//  wen          out  1   slave write enable, ACCESS only
//  slv_addr     out  32  latched request address
//  slv_wdata    out  32  latched write data
//  rdata_in     in   32  arbitrated slave read data
// BEHAVIOUR
//  Reset (async, nRST=0): state IDLE; all outputs 0; addr/wdata/rdata regs 0; counter 0.
//  Reset mid-transfer: selects/enables drop immediately, no ready issued, request is lost.
//  FSM IDLE -> ACCESS -> RESP -> IDLE; IDLE -> ERR -> IDLE.
//  IDLE: on req_ren^req_wen latch addr, wdata, op, decode. Priority 1>2>3 on overlap.
//    Hit -> ACCESS with cnt=LATn. Miss -> ERR. req_ren&req_wen -> ERR, no slave access.
//  ACCESS: exactly one addr_valid_n=1 plus ren or wen, stable all cycles. cnt-- each cycle.
//    When cnt==0: capture rdata_in into rdata_out (reads only) and go to RESP.
//  RESP: ready=1, error=0, one cycle; selects/enables low; then IDLE.
//  ERR: ready=1, error=1, one cycle; rdata_out holds its previous value.
//  Latency: request at edge k, ACCESS edges k+1..k+1+LATn, ready high in cycle k+2+LATn.
//  Requests while busy are ignored (no queueing). A new request may be sampled in the
//    IDLE cycle right after ready.
//  rdata_out keeps its value until the next successful read capture. Writes leave it unchanged.
//  cnt is 4 bits and never wraps: loaded at IDLE->ACCESS, ACCESS exits at 0.
//  busy = (state != IDLE). ready and busy are both high during RESP and ERR.
// TESTING
//  Read 0x8000_0004, rdata_in=0xDEADBEEF -> addr_valid1&ren for 1 cycle; ready 2 cycles later; rdata_out=0xDEADBEEF.
//  Write 0x8002_0010 wdata=0x1234 -> addr_valid3&wen held 6 cycles, slv_wdata=0x1234; ready, error=0, rdata_out unchanged.
//  Read 0x9000_0000 -> no addr_valid/ren; ready=error=1 next cycle; busy 1 cycle.
//  req_ren=req_wen=1 at 0x8001_0000 -> ERR, error=1, no slave enable asserted.
//  Read 0x8001_0000 with new req pulses during ACCESS -> extra requests ignored, one ready only.
//  nRST low in 2nd ACCESS cycle of region-3 read -> all outputs 0 at once; IDLE; no ready after release.

Source files
------------

// File: rtl/bus_access_sequencer.sv
// bus_access_sequencer
// Master-facing front end of the peripheral read/write path. A single request
// is decoded against three address regions. The matching slave select is held
// with ren/wen for that region's fixed wait-state count. The read data is then
// captured and a one-cycle ready strobe is returned. Unmapped addresses and
// requests with both ren and wen set complete through a one-cycle error
// response and do not touch any slave.

module bus_access_sequencer #(
  parameter logic [31:0] BASE1 = 32'h8000_0000,
  parameter logic [31:0] MASK1 = 32'hFFFF_0000,
  parameter logic [31:0] BASE2 = 32'h8001_0000,
  parameter logic [31:0] MASK2 = 32'hFFFF_0000,
  parameter logic [31:0] BASE3 = 32'h8002_0000,
  parameter logic [31:0] MASK3 = 32'hFFFF_0000,
  parameter int unsigned LAT1  = 0,
  parameter int unsigned LAT2  = 2,
  parameter int unsigned LAT3  = 5
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] req_addr,
  input  logic        req_ren,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        ready,
  output logic        error,
  output logic [31:0] rdata_out,
  output logic        addr_valid1,
  output logic        addr_valid2,
  output logic        addr_valid3,
  output logic        ren,
  output logic        wen,
  output logic [31:0] slv_addr,
  output logic [31:0] slv_wdata,
  input  logic [31:0] rdata_in
);

  localparam int NREG = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic [1:0] ST_ERR    = 2'd3;

  // Region tables, index 0 is region 1 (highest priority on overlap).
  localparam logic [31:0] BASE_TAB [NREG] = '{BASE1, BASE2, BASE3};
  localparam logic [31:0] MASK_TAB [NREG] = '{MASK1, MASK2, MASK3};
  // Wait-state counts are 0..15 and fit the 4-bit down-counter.
  localparam logic [3:0]  LAT_TAB  [NREG] = '{4'(LAT1), 4'(LAT2), 4'(LAT3)};

  logic [1:0]      state_q,   state_d;
  logic [31:0]     addr_q,    addr_d;
  logic [31:0]     wdata_q,   wdata_d;
  logic [31:0]     rdata_q,   rdata_d;
  logic            is_read_q, is_read_d;
  logic [NREG-1:0] sel_q,     sel_d;
  logic [3:0]      cnt_q,     cnt_d;

  logic [NREG-1:0] hit;
  logic [NREG-1:0] sel_dec;
  logic [3:0]      lat_dec;
  logic            in_access;

  // Raw region match and priority resolution (lower index wins on overlap).
  for (genvar gi = 0; gi < NREG; gi++) begin : g_decode
    assign hit[gi] = ((req_addr & MASK_TAB[gi]) == BASE_TAB[gi]);
    if (gi == 0) begin : g_first
      assign sel_dec[gi] = hit[gi];
    end else begin : g_rest
      assign sel_dec[gi] = hit[gi] & ~(|hit[gi-1:0]);
    end
  end

  // Wait-state count of the selected region (sel_dec is one-hot or zero).
  always_comb begin
    lat_dec = 4'd0;
    for (int i = 0; i < NREG; i++) begin
      if (sel_dec[i]) begin
        lat_dec = lat_dec | LAT_TAB[i];
      end
    end
  end

  // Next-state and datapath updates for the IDLE/ACCESS/RESP/ERR sequence.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    is_read_d = is_read_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (req_ren && req_wen) begin
          // Ambiguous request: report it without latching or accessing.
          state_d = ST_ERR;
        end else if (req_ren || req_wen) begin
          addr_d    = req_addr;
          is_read_d = req_ren;
          if (req_wen) begin
            wdata_d = req_wdata;
          end
          if (|sel_dec) begin
            sel_d   = sel_dec;
            cnt_d   = lat_dec;
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_ERR;
          end
        end
      end

      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (is_read_q) begin
            rdata_d = rdata_in;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= ST_IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      is_read_q <= 1'b0;
      sel_q     <= '0;
      cnt_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      is_read_q <= is_read_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
    end
  end

  // Slave-facing strobes are qualified by the state register alone, so they
  // drop as soon as reset clears the state.
  assign in_access   = (state_q == ST_ACCESS);
  assign addr_valid1 = in_access & sel_q[0];
  assign addr_valid2 = in_access & sel_q[1];
  assign addr_valid3 = in_access & sel_q[2];
  assign ren         = in_access & is_read_q;
  assign wen         = in_access & ~is_read_q;

  assign busy        = (state_q != ST_IDLE);
  assign ready       = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign error       = (state_q == ST_ERR);

  assign slv_addr    = addr_q;
  assign slv_wdata   = wdata_q;
  assign rdata_out   = rdata_q;

endmodule
